// File: rtl/var_line_buffer.sv
// Variable-spacing line buffer: pNoTaps taps spaced active_spacing samples apart,
// built from chained circular stores. LINE_BUFFER_FILL_TRACK_EN enables fill tracking and tap masking.
module var_line_buffer #(
    parameter int pNoTaps     = 4,
    parameter int pMaxSpacing = 64,
    parameter int pPtrLength  = 7,
    parameter int pDataLength = 12
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           clear,
    input  logic                           enable,
    input  logic                           spacing_load,
    input  logic [pPtrLength-1:0]          spacing,
    input  logic [pDataLength-1:0]         shift_in,
    output logic [pDataLength*pNoTaps-1:0] taps,
    output logic                           taps_valid,
    output logic [pPtrLength-1:0]          active_spacing
);

    localparam int AW = (pMaxSpacing > 1) ? $clog2(pMaxSpacing) : 1;
    localparam int NS = pNoTaps - 1;
    localparam logic [pPtrLength-1:0] MAX_SP = pPtrLength'(pMaxSpacing);

    logic [pDataLength-1:0] store_mem [NS][pMaxSpacing];
    logic [pDataLength-1:0] rd_data   [NS];
    logic [pDataLength-1:0] wr_data   [NS];
    logic [pDataLength-1:0] tap_raw   [pNoTaps];
    logic [pDataLength-1:0] tap_q     [pNoTaps];
    logic [pDataLength-1:0] tap_d     [pNoTaps];
    logic                   unmask    [pNoTaps];

    logic [AW-1:0]         ptr_q, ptr_d;
    logic [pPtrLength-1:0] spacing_q, spacing_d;
    logic                  valid_q, valid_d;
    logic                  flush, advance, ptr_last;

    assign flush    = clear | spacing_load;
    assign advance  = enable & ~flush;
    assign ptr_last = (ptr_q == AW'(spacing_q - pPtrLength'(1)));

    // Stage 0 stores the incoming sample; each later stage stores what the previous stage just read,
    // so every stage adds exactly active_spacing enables of delay.
    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_stage
            assign rd_data[gi] = store_mem[gi][ptr_q];
            if (gi == 0) begin : g_first
                assign wr_data[gi] = shift_in;
            end else begin : g_chain
                assign wr_data[gi] = rd_data[gi-1];
            end
        end
        for (genvar gi = 0; gi < pNoTaps; gi++) begin : g_tap
            if (gi == 0) begin : g_t0
                assign tap_raw[gi] = shift_in;
            end else begin : g_tk
                assign tap_raw[gi] = rd_data[gi-1];
            end
            assign taps[pDataLength*gi +: pDataLength] = tap_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (advance) begin
            for (int s = 0; s < NS; s++) begin
                store_mem[s][ptr_q] <= wr_data[s];
            end
        end
    end

`ifdef LINE_BUFFER_FILL_TRACK_EN
    localparam int FW = $clog2(NS * pMaxSpacing + 2);

    logic [FW-1:0] fill_q, fill_d, fill_sat;
    logic [FW-1:0] thr [pNoTaps];

    assign fill_sat = FW'(NS) * FW'(spacing_q) + FW'(1);

    generate
        for (genvar gi = 0; gi < pNoTaps; gi++) begin : g_mask
            assign thr[gi]    = FW'(gi) * FW'(spacing_q) + FW'(1);
            assign unmask[gi] = (fill_d >= thr[gi]);
        end
    endgenerate

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = '0;
        end else if (advance && (fill_q != fill_sat)) begin
            fill_d = fill_q + FW'(1);
        end
        valid_d = (fill_d == fill_sat);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end
`else
    generate
        for (genvar gi = 0; gi < pNoTaps; gi++) begin : g_mask
            assign unmask[gi] = 1'b1;
        end
    endgenerate

    always_comb begin
        valid_d = advance;
    end
`endif

    always_comb begin
        spacing_d = spacing_q;
        if (spacing_load) begin
            if (spacing == '0) begin
                spacing_d = pPtrLength'(1);
            end else if (spacing > MAX_SP) begin
                spacing_d = MAX_SP;
            end else begin
                spacing_d = spacing;
            end
        end

        ptr_d = ptr_q;
        if (flush) begin
            ptr_d = '0;
        end else if (advance) begin
            ptr_d = ptr_last ? '0 : ptr_q + AW'(1);
        end

        for (int k = 0; k < pNoTaps; k++) begin
            tap_d[k] = tap_q[k];
            if (flush) begin
                tap_d[k] = '0;
            end else if (advance) begin
                tap_d[k] = unmask[k] ? tap_raw[k] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q     <= '0;
            spacing_q <= MAX_SP;
            valid_q   <= 1'b0;
            for (int k = 0; k < pNoTaps; k++) begin
                tap_q[k] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            spacing_q <= spacing_d;
            valid_q   <= valid_d;
            for (int k = 0; k < pNoTaps; k++) begin
                tap_q[k] <= tap_d[k];
            end
        end
    end

    assign taps_valid     = valid_q;
    assign active_spacing = spacing_q;

endmodule

// File: tb/tb_var_line_buffer.sv
// Randomized self-checking bench for var_line_buffer against a sample-history reference model.
// Expectations follow LINE_BUFFER_FILL_TRACK_EN when it is defined for the build.
module tb_var_line_buffer;

    localparam int NT = 4;
    localparam int MS = 64;
    localparam int PL = 7;
    localparam int DL = 12;
`ifdef LINE_BUFFER_FILL_TRACK_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              clear = 1'b0;
    logic              enable = 1'b0;
    logic              spacing_load = 1'b0;
    logic [PL-1:0]     spacing = '0;
    logic [DL-1:0]     shift_in = '0;
    logic [DL*NT-1:0]  taps;
    logic              taps_valid;
    logic [PL-1:0]     active_spacing;

    var_line_buffer #(
        .pNoTaps(NT), .pMaxSpacing(MS), .pPtrLength(PL), .pDataLength(DL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable),
        .spacing_load(spacing_load), .spacing(spacing), .shift_in(shift_in),
        .taps(taps), .taps_valid(taps_valid), .active_spacing(active_spacing)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: samples accepted since the last flush, newest at the back.
    logic [DL-1:0] hist[$];
    int            n_m = 0;
    int            s_m = MS;
    bit            last_en_m = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        n_m = 0;
        s_m = MS;
        last_en_m = 1'b0;
    endtask

    task automatic model_step(input bit en, input logic [DL-1:0] din, input bit clr,
                              input bit ld, input int sp);
        if (ld) begin
            s_m = (sp == 0) ? 1 : ((sp > MS) ? MS : sp);
        end
        if (ld || clr) begin
            hist.delete();
            n_m = 0;
            last_en_m = 1'b0;
        end else if (en) begin
            hist.push_back(din);
            if (hist.size() > 400) void'(hist.pop_front());
            n_m++;
            last_en_m = 1'b1;
        end else begin
            last_en_m = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        logic exp_valid;
        for (int k = 0; k < NT; k++) begin
            if (n_m >= k * s_m + 1) begin
                check_val($sformatf("%s_tap%0d", tag, k), 64'(taps[DL*k +: DL]),
                          64'(hist[hist.size() - 1 - k * s_m]));
            end else if (FILL_EN || n_m == 0) begin
                check_val($sformatf("%s_tap%0d_zero", tag, k), 64'(taps[DL*k +: DL]), 64'd0);
            end
        end
        exp_valid = FILL_EN ? (n_m >= (NT - 1) * s_m + 1) : last_en_m;
        check_val({tag, "_valid"}, 64'(taps_valid), 64'(exp_valid));
        check_val({tag, "_spacing"}, 64'(active_spacing), 64'(s_m));
    endtask

    // One clock of stimulus; called just after a rising edge (or from a falling edge).
    task automatic cycle(input string tag, input bit en, input logic [DL-1:0] din,
                         input bit clr, input bit ld, input int sp);
        enable = en; shift_in = din; clear = clr; spacing_load = ld; spacing = PL'(sp);
        @(posedge clk);
        model_step(en, din, clr, ld, sp);
        #1;
        $display("%s en=%0b clr=%0b ld=%0b sp=%0d din=%h -> taps=%h valid=%0b act=%0d",
                 tag, en, clr, ld, sp, din, taps, taps_valid, active_spacing);
        compare_all(tag);
        enable = 1'b0; clear = 1'b0; spacing_load = 1'b0;
    endtask

    initial begin
        logic [DL*NT-1:0] exp_taps;
        int refill;

        model_reset();
        #12;
        check_val("rst_taps", 64'(taps), 64'd0);
        check_val("rst_valid", 64'(taps_valid), 64'd0);
        check_val("rst_spacing", 64'(active_spacing), 64'(MS));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Spacing 3, back-to-back ramp 1..10.
        cycle("load3", 1'b0, '0, 1'b0, 1'b1, 3);
        for (int i = 1; i <= 10; i++) cycle("ramp", 1'b1, DL'(i), 1'b0, 1'b0, 0);
        exp_taps = {12'd1, 12'd4, 12'd7, 12'd10};
        check_val("ramp_taps", 64'(taps), 64'(exp_taps));

        // Same ramp with enable alternating; idle cycles must hold.
        cycle("load3b", 1'b0, '0, 1'b0, 1'b1, 3);
        for (int i = 1; i <= 10; i++) begin
            cycle("alt_en", 1'b1, DL'(i), 1'b0, 1'b0, 0);
            cycle("alt_idle", 1'b0, DL'($urandom), 1'b0, 1'b0, 0);
        end
        check_val("alt_taps", 64'(taps), 64'(exp_taps));

        // Spacing clamping, then spacing 1.
        cycle("load0", 1'b0, '0, 1'b0, 1'b1, 0);
        check_val("clamp_lo", 64'(active_spacing), 64'd1);
        cycle("load100", 1'b0, '0, 1'b0, 1'b1, 100);
        check_val("clamp_hi", 64'(active_spacing), 64'd64);
        cycle("load1", 1'b0, '0, 1'b0, 1'b1, 1);
        for (int i = 21; i <= 26; i++) cycle("sp1", 1'b1, DL'(i), 1'b0, 1'b0, 0);
        check_val("sp1_tap3", 64'(taps[DL*3 +: DL]), 64'd23);

        // Clear colliding with enable after 20 samples.
        cycle("load3c", 1'b0, '0, 1'b0, 1'b1, 3);
        for (int i = 0; i < 20; i++) cycle("fill20", 1'b1, DL'($urandom), 1'b0, 1'b0, 0);
        cycle("clr_en", 1'b1, 12'hABC, 1'b1, 1'b0, 0);
        check_val("clr_taps", 64'(taps), 64'd0);
        check_val("clr_valid", 64'(taps_valid), 64'd0);
        cycle("after_clr", 1'b1, 12'h5A5, 1'b0, 1'b0, 0);
        check_val("after_clr_tap0", 64'(taps[DL-1:0]), 64'h5A5);

        // Asynchronous reset mid-fill, then refill timing.
        cycle("load3d", 1'b0, '0, 1'b0, 1'b1, 3);
        for (int i = 0; i < 7; i++) cycle("prefill", 1'b1, DL'($urandom), 1'b0, 1'b0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_val("arst_taps", 64'(taps), 64'd0);
        check_val("arst_valid", 64'(taps_valid), 64'd0);
        check_val("arst_spacing", 64'(active_spacing), 64'(MS));
        @(negedge clk);
        reset_n = 1'b1;
        cycle("load3e", 1'b0, '0, 1'b0, 1'b1, 3);
        refill = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle("refill", 1'b1, DL'($urandom), 1'b0, 1'b0, 0);
            if (taps_valid && refill == 0) refill = i;
        end
        check_val("refill_len", 64'(refill), FILL_EN ? 64'd10 : 64'd1);

        // Spacing 2: first enable and what taps_valid does next cycle.
        cycle("load2", 1'b0, '0, 1'b0, 1'b1, 2);
        cycle("sp2_first", 1'b1, 12'h123, 1'b0, 1'b0, 0);
`ifndef LINE_BUFFER_FILL_TRACK_EN
        check_val("nofill_valid", 64'(taps_valid), 64'd1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            int sp;
            r = int'($urandom_range(0, 99));
            sp = (r == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 6));
            cycle("rand", ($urandom_range(0, 9) < 6), DL'($urandom), (r == 1 || r == 2),
                  (r == 0 || r == 3), sp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
